// File: rtl/hazard_scoreboard_fwd_pkg.sv
// hazard_scoreboard_fwd_pkg: shared constants for the hazard scoreboard/forwarding block
package hazard_scoreboard_fwd_pkg;
  localparam int NREG_DEF = 32;
  localparam int REG_AW = $clog2(NREG_DEF);
  localparam int STG_EX = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB = 2;
  localparam int ADDR_SLICE_W = REG_AW;
  localparam int DATA_SLICE_W = 32;
endpackage

// File: rtl/hazard_fwd_port.sv
// hazard_fwd_port: per-read-port youngest-first bypass match, forward mux and stall term
module hazard_fwd_port
  import hazard_scoreboard_fwd_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int DATA_W = DATA_SLICE_W,
  parameter int AW = ADDR_SLICE_W
) (
  input  logic [AW-1:0]                rd_addr,
  input  logic [NUM_STAGES-1:0]        stg_we,
  input  logic [NUM_STAGES-1:0]        stg_ready,
  input  logic [NUM_STAGES*AW-1:0]     stg_waddr,
  input  logic [NUM_STAGES*DATA_W-1:0] stg_data,
  input  logic                         cnt_nz,
  output logic                         hit,
  output logic [DATA_W-1:0]            data,
  output logic                         stall
);
  logic found, rdy, nz;
  logic [DATA_W-1:0] dat;
  always_comb begin
    found = 1'b0;
    rdy = 1'b0;
    dat = '0;
    // oldest first so the youngest match overwrites
    for (int i = NUM_STAGES - 1; i >= 0; i--)
      if (stg_we[i] && stg_waddr[i*AW +: AW] == rd_addr) begin
        found = 1'b1;
        rdy = stg_ready[i];
        dat = stg_data[i*DATA_W +: DATA_W];
      end
    nz = rd_addr != '0;
    hit = nz & found & rdy;
    data = hit ? dat : '0;
    stall = nz & (found ? ~rdy : cnt_nz);
  end
endmodule

// File: rtl/hazard_scoreboard_fwd.sv
// hazard_scoreboard_fwd: in-flight write scoreboard with multi-stage forwarding and ID stall
module hazard_scoreboard_fwd
  import hazard_scoreboard_fwd_pkg::*;
#(
  parameter int NUM_RPORTS = 2,
  parameter int NUM_STAGES = 3,
  parameter int DATA_W = DATA_SLICE_W,
  parameter int NREG = NREG_DEF,
  parameter int CNT_W = 2,
  localparam int AW = $clog2(NREG)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         issue_valid,
  input  logic                         issue_we,
  input  logic [AW-1:0]                issue_waddr,
  input  logic                         retire_valid,
  input  logic                         retire_we,
  input  logic [AW-1:0]                retire_waddr,
  input  logic [NUM_STAGES-1:0]        stg_we,
  input  logic [NUM_STAGES-1:0]        stg_ready,
  input  logic [NUM_STAGES*AW-1:0]     stg_waddr,
  input  logic [NUM_STAGES*DATA_W-1:0] stg_data,
  input  logic [NUM_RPORTS*AW-1:0]     rd_addr,
  output logic [NUM_RPORTS-1:0]        rd_hit,
  output logic [NUM_RPORTS*DATA_W-1:0] rd_data,
  output logic                         stall,
  output logic                         err,
  output logic [31:0]                  stall_cnt
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [CNT_W-1:0] cnt [NREG];
  logic [NUM_RPORTS-1:0] port_stall;
  logic iss, ret, same, ovf;
  always_comb begin
    iss = issue_valid & issue_we & (issue_waddr != '0);
    ret = retire_valid & retire_we & (retire_waddr != '0);
    same = iss & ret & (issue_waddr == retire_waddr);
    ovf = issue_we & (cnt[issue_waddr] == CMAX);
    stall = ~flush & ((|port_stall) | ovf);
  end
  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
    hazard_fwd_port #(
      .NUM_STAGES(NUM_STAGES),
      .DATA_W(DATA_W),
      .AW(AW)
    ) u_port (
      .rd_addr(rd_addr[p*AW +: AW]),
      .stg_we(stg_we),
      .stg_ready(stg_ready),
      .stg_waddr(stg_waddr),
      .stg_data(stg_data),
      .cnt_nz(cnt[rd_addr[p*AW +: AW]] != '0),
      .hit(rd_hit[p]),
      .data(rd_data[p*DATA_W +: DATA_W]),
      .stall(port_stall[p])
    );
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush) begin
        for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else if (!same) begin
        if (iss) begin
          if (cnt[issue_waddr] == CMAX) err <= 1'b1;
          else cnt[issue_waddr] <= cnt[issue_waddr] + 1'b1;
        end
        if (ret) begin
          if (cnt[retire_waddr] == '0) err <= 1'b1;
          else cnt[retire_waddr] <= cnt[retire_waddr] - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard_fwd.sv
// tb_hazard_scoreboard_fwd: directed vector table plus scoreboard sequences
module tb_hazard_scoreboard_fwd;
  localparam logic [31:0] D0 = 32'h0000_1234;
  localparam logic [31:0] D1 = 32'hAAAA_0001;
  localparam logic [31:0] D2 = 32'hBBBB_0002;
  logic clk = 1'b0;
  logic resetn, flush, issue_valid, issue_we, retire_valid, retire_we;
  logic [4:0] issue_waddr, retire_waddr;
  logic [2:0] stg_we, stg_ready;
  logic [14:0] stg_waddr;
  logic [95:0] stg_data;
  logic [9:0] rd_addr;
  logic [1:0] rd_hit;
  logic [63:0] rd_data;
  logic stall, err;
  logic [31:0] stall_cnt, sc;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [2:0] we, rdy;
    logic [4:0] wa0, wa1, wa2, ra0, ra1;
    logic [1:0] hit;
    logic [31:0] d0, d1;
    logic st;
  } vec_t;
  vec_t tv[10];
  hazard_scoreboard_fwd dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_waddr(issue_waddr),
    .retire_valid(retire_valid), .retire_we(retire_we), .retire_waddr(retire_waddr),
    .stg_we(stg_we), .stg_ready(stg_ready), .stg_waddr(stg_waddr), .stg_data(stg_data),
    .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
    .stall(stall), .err(err), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic iv, input logic iw, input logic [4:0] ia,
                     input logic rv, input logic rw, input logic [4:0] ra, input logic fl);
    issue_valid = iv; issue_we = iw; issue_waddr = ia;
    retire_valid = rv; retire_we = rw; retire_waddr = ra; flush = fl;
    @(posedge clk); #1;
    issue_valid = 0; issue_we = 0; issue_waddr = 0;
    retire_valid = 0; retire_we = 0; retire_waddr = 0; flush = 0;
  endtask
  task automatic probe(input string nm, input logic [4:0] r, input logic exp);
    stg_we = 3'b000;
    rd_addr = {5'd0, r};
    #1;
    chk(nm, stall, exp);
  endtask
  initial begin
    tv[0] = '{3'b001, 3'b001, 5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 2'b01, D0, 32'd0, 1'b0};
    tv[1] = '{3'b011, 3'b010, 5'd7, 5'd7, 5'd0, 5'd7, 5'd0, 2'b00, 32'd0, 32'd0, 1'b1};
    tv[2] = '{3'b110, 3'b110, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 2'b10, 32'd0, D1, 1'b0};
    tv[3] = '{3'b100, 3'b100, 5'd0, 5'd0, 5'd8, 5'd8, 5'd8, 2'b11, D2, D2, 1'b0};
    tv[4] = '{3'b001, 3'b001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 32'd0, 32'd0, 1'b0};
    tv[5] = '{3'b000, 3'b111, 5'd6, 5'd6, 5'd6, 5'd6, 5'd6, 2'b00, 32'd0, 32'd0, 1'b0};
    tv[6] = '{3'b011, 3'b001, 5'd5, 5'd2, 5'd0, 5'd5, 5'd2, 2'b01, D0, 32'd0, 1'b1};
    tv[7] = '{3'b101, 3'b101, 5'd4, 5'd0, 5'd4, 5'd4, 5'd0, 2'b01, D0, 32'd0, 1'b0};
    tv[8] = '{3'b110, 3'b010, 5'd0, 5'd9, 5'd9, 5'd9, 5'd0, 2'b01, D1, 32'd0, 1'b0};
    tv[9] = '{3'b110, 3'b100, 5'd0, 5'd9, 5'd9, 5'd0, 5'd9, 2'b00, 32'd0, 32'd0, 1'b1};
    resetn = 0; flush = 0;
    issue_valid = 0; issue_we = 0; issue_waddr = 0;
    retire_valid = 0; retire_we = 0; retire_waddr = 0;
    stg_we = 0; stg_ready = 0; stg_waddr = 0; stg_data = {D2, D1, D0}; rd_addr = 0;
    #1;
    chk("reset_hit", {30'd0, rd_hit}, 0);
    chk("reset_stall", stall, 0);
    chk("reset_err", err, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_rd_data", rd_data[31:0], 0);
    #11 resetn = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      stg_we = tv[i].we; stg_ready = tv[i].rdy;
      stg_waddr = {tv[i].wa2, tv[i].wa1, tv[i].wa0};
      rd_addr = {tv[i].ra1, tv[i].ra0};
      #1;
      chk($sformatf("vec%0d_hit", i), {30'd0, rd_hit}, {30'd0, tv[i].hit});
      chk($sformatf("vec%0d_d0", i), rd_data[31:0], tv[i].d0);
      chk($sformatf("vec%0d_d1", i), rd_data[63:32], tv[i].d1);
      chk($sformatf("vec%0d_stall", i), stall, tv[i].st);
    end
    stg_we = 3'b001; stg_ready = 3'b000; stg_waddr = {5'd0, 5'd0, 5'd7}; rd_addr = {5'd0, 5'd7};
    @(posedge clk); #1;
    sc = stall_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_cnt_plus3", stall_cnt, sc + 3);
    stg_we = 0;
    cyc(1, 1, 9, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    probe("div_r9_stall", 9, 1);
    retire_valid = 1; retire_we = 1; retire_waddr = 9;
    #1;
    chk("div_pre_retire_stall", stall, 1);
    cyc(0, 0, 0, 1, 1, 9, 0);
    probe("div_post_retire", 9, 0);
    cyc(1, 1, 4, 0, 0, 0, 0);
    cyc(1, 1, 4, 1, 1, 4, 0);
    probe("r4_same_cycle_kept", 4, 1);
    chk("r4_no_err", err, 0);
    cyc(0, 0, 0, 1, 1, 4, 0);
    probe("r4_retired", 4, 0);
    chk("r4_still_no_err", err, 0);
    cyc(0, 0, 0, 1, 1, 4, 0);
    chk("r4_underflow_err", err, 1);
    probe("r4_stays_zero", 4, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", err, 1);
    stg_we = 3'b001; stg_ready = 3'b000; stg_waddr = {5'd0, 5'd0, 5'd7}; rd_addr = {5'd0, 5'd7};
    @(posedge clk); #1;
    chk("stall_before_reset", stall, 1);
    resetn = 0;
    #1;
    chk("async_reset_stall_cnt", stall_cnt, 0);
    chk("async_reset_err", err, 0);
    #3 resetn = 1;
    stg_we = 0;
    @(posedge clk); #1;
    probe("r9_cleared_by_reset", 9, 0);
    repeat (3) cyc(1, 1, 3, 0, 0, 0, 0);
    chk("r3_full_no_err", err, 0);
    rd_addr = 0; issue_we = 1; issue_waddr = 3;
    #1;
    chk("r3_ovf_stall", stall, 1);
    issue_waddr = 4;
    #1;
    chk("r4_no_ovf_stall", stall, 0);
    issue_we = 0; issue_waddr = 0;
    cyc(1, 1, 3, 0, 0, 0, 0);
    chk("r3_ovf_err", err, 1);
    probe("r3_stays_max", 3, 1);
    cyc(1, 1, 9, 0, 0, 0, 0);
    cyc(1, 1, 9, 0, 0, 0, 0);
    probe("r9_cnt2_stall", 9, 1);
    flush = 1;
    #1;
    chk("flush_gates_stall", stall, 0);
    flush = 0;
    cyc(1, 1, 9, 0, 0, 0, 1);
    probe("flush_clears_r9", 9, 0);
    probe("flush_clears_r3", 3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard_fwd.md
Name: hazard_scoreboard_fwd

Overview:
- Parametrised successor to the ID-stage data hazard detector.
- Per-register in-flight write scoreboard (counters), updated on issue and retire handshakes. Covers long-latency producers (mul/div, load, csr) that may leave the bypass window while their result is still unavailable.
- Forwards from N pipeline stages over M read ports, youngest first.
- Generates ID stall, a sticky protocol-error flag and a saturating stall-cycle counter.

Parameters:
- NUM_RPORTS, 2, number of register read ports checked.
- NUM_STAGES, 3, number of bypass stages. Index 0 is the youngest (EX); the highest index is the oldest (WB).
- DATA_W, 32, forwarded data width.
- NREG, 32, architectural register count. Register 0 is hardwired zero.
- CNT_W, 2, width of each per-register in-flight counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush (exception/ertn); squashes all in-flight producers.
- issue_valid  in  1  instruction leaves ID this cycle (ID→EX fire).
- issue_we  in  1  issuing instruction writes the register file.
- issue_waddr  in  log2(NREG)  issuing destination register.
- retire_valid  in  1  WB commits this cycle.
- retire_we  in  1  committing instruction writes the register file.
- retire_waddr  in  log2(NREG)  committing destination register.
- stg_we  in  NUM_STAGES  per-stage write enable (already qualified by stage valid).
- stg_ready  in  NUM_STAGES  per-stage result available for forwarding.
- stg_waddr  in  NUM_STAGES*log2(NREG)  per-stage destination register, packed.
- stg_data  in  NUM_STAGES*DATA_W  per-stage result, packed.
- rd_addr  in  NUM_RPORTS*log2(NREG)  ID read addresses, packed.
- rd_hit  out  NUM_RPORTS  forward-select, one per port.
- rd_data  out  NUM_RPORTS*DATA_W  forwarded values, packed.
- stall  out  1  hold the ID stage.
- err  out  1  sticky protocol error.
- stall_cnt  out  32  saturating count of stall cycles.

Behaviour:
- Reset (resetn=0, asynchronous): all counters 0, err=0, stall_cnt=0.
- Outputs during reset:
  - rd_hit=0 and stall=0 while rd_addr is 0.
  - rd_data is a don't-care when rd_hit=0; the implementation drives 0.
- Forwarding (combinational, per port p):
  - Candidate stages: stg_we[i] & stg_waddr[i]==rd_addr[p] & rd_addr[p]!=0.
  - The lowest-index matching stage wins.
  - rd_hit[p]=1 and rd_data[p]=stg_data[winner] when the winner's stg_ready=1.
- Stall per port (combinational):
  - Asserted when rd_addr[p]!=0 and either:
    - the winning stage has stg_ready=0, or
    - no stage matches but cnt[rd_addr[p]]!=0 (producer outside the window, e.g. in a divider).
  - Additional stall term: issue_we & cnt[issue_waddr]==2^CNT_W-1, which prevents counter overflow.
  - stall is the OR of all terms, gated by ~flush.
- Counter update at posedge clk, in priority order:
  1. flush=1: all counters cleared. issue and retire in the same cycle are ignored.
  2. Issue and retire to the same register in the same cycle: counter unchanged.
  3. issue_valid&issue_we: cnt[issue_waddr]+1.
  4. retire_valid&retire_we: cnt[retire_waddr]-1.
- Register 0 never counts.
- Error conditions (set err, which stays set until reset):
  - Retire to a register whose counter is 0: counter stays 0.
  - Issue while the counter is at max: counter stays at max.
- stall_cnt increments on every cycle with stall=1 and saturates at 0xFFFF_FFFF.
- stall and the forward outputs have zero latency. Counter effects become visible one cycle after the handshake.

Decomposition:
- Shared package holds:
  - the REG_AW=log2(NREG) constant;
  - the stage index constants STG_EX=0, STG_MEM=1, STG_WB=2;
  - the packed-bus slice widths.
- One sub-module, hazard_fwd_port: per-port priority match, forward mux and stall term. It is instantiated NUM_RPORTS times by generate.
- The scoreboard counters and stall_cnt stay in the top module.

Test Plan:
- EX add to r5 with ready=1; ID reads r5 on port 0 → rd_hit[0]=1, rd_data=EX data (0x1234), stall=0.
- EX load to r7 with ready=0; MEM also writes r7 with ready=1 → stall=1; EX wins priority, so MEM is not forwarded.
- Issue div to r9, 3 cycles later no stage matches r9; ID reads r9 → stall=1 until a retire of r9, then stall=0 the next cycle.
- Issue and retire r4 in the same cycle with cnt[4]=1 → cnt stays 1; a retire of r4 with cnt 0 → err=1 and stays 1.
- Issue three writes to r3 (CNT_W=2), then a fourth with issue_we → stall=1; forcing issue anyway → err=1.
- flush with cnt[9]=2 → all counters 0 next cycle, stall=0; resetn low mid-stall → stall_cnt=0 immediately.
